// File: rtl/decode_pkg.sv
// Shared opcode, flag-position and micro-op definitions for the decode sequencer.
package decode_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_NOR = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_SRL = 4'h5;
  localparam logic [3:0] OP_SRA = 4'h6;
  localparam logic [3:0] OP_JLR = 4'h7;
  localparam logic [3:0] OP_STB = 4'hD;
  localparam logic [3:0] OP_LDB = 4'hE;
  localparam logic [3:0] OP_LDI = 4'hF;

  localparam int unsigned ALU_CI = 7;
  localparam int unsigned ALU_NB = 6;
  localparam int unsigned ALU_IC = 5;
  localparam int unsigned ALU_NA = 4;
  localparam int unsigned ALU_XO = 3;
  localparam int unsigned ALU_NO = 2;
  localparam int unsigned ALU_SR = 1;
  localparam int unsigned ALU_SS = 0;

  localparam int unsigned CTRL_LD  = 0;
  localparam int unsigned CTRL_MR  = 1;
  localparam int unsigned CTRL_MW  = 2;
  localparam int unsigned CTRL_SPC = 3;
  localparam int unsigned CTRL_WPC = 4;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  typedef struct packed {
    logic [7:0] alu;
    logic [7:0] ctrl;
    logic       last;
    logic       illegal;
  } uop_t;

  function automatic logic [7:0] flag(input int unsigned pos);
    return 8'd1 << pos;
  endfunction

  function automatic int unsigned num_steps(input logic [3:0] op);
    return (op == OP_JLR || op == OP_LDB) ? 2 : 1;
  endfunction

endpackage

// File: rtl/decode_sequencer_if.sv
// Fetch-side and execute-side handshake bundle of the decode sequencer.
interface decode_sequencer_if #(
  parameter int unsigned OPC_W     = 4,
  parameter int unsigned ALU_W     = 8,
  parameter int unsigned CTRL_W    = 8,
  parameter int unsigned MAX_STEPS = 2
);
  localparam int unsigned STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [OPC_W-1:0]  opcode;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [ALU_W-1:0]  alu_flags;
  logic [CTRL_W-1:0] ctrl_flags;
  logic [STEP_W-1:0] step;
  logic              last;
  logic              illegal;

  modport master (
    output in_valid, opcode, flush, out_ready,
    input  in_ready, out_valid, alu_flags, ctrl_flags, step, last, illegal
  );

  modport slave (
    input  in_valid, opcode, flush, out_ready,
    output in_ready, out_valid, alu_flags, ctrl_flags, step, last, illegal
  );

endinterface

// File: rtl/uop_rom.sv
// Combinational (opcode, step) -> micro-op lookup; any opcode bit above bit 3 makes it illegal.
module uop_rom
  import decode_pkg::*;
#(
  parameter int unsigned OPC_W  = 4,
  parameter int unsigned STEP_W = 1
) (
  input  logic [OPC_W-1:0]  opcode_i,
  input  logic [STEP_W-1:0] step_i,
  output uop_t              uop_o
);

  logic [3:0] op_lo;
  logic       hi_set;
  logic       second;

  assign op_lo  = opcode_i[3:0];
  assign hi_set = |(opcode_i >> 4);
  assign second = (step_i != '0);

  always_comb begin
    uop_o = '0;
    if (hi_set) begin
      uop_o.illegal = 1'b1;
    end else begin
      case (op_lo)
        OP_ADD: uop_o.alu = '0;
        OP_SUB: uop_o.alu = flag(ALU_CI) | flag(ALU_NB);
        OP_XOR: uop_o.alu = flag(ALU_IC);
        OP_NOR: uop_o.alu = flag(ALU_IC) | flag(ALU_XO) | flag(ALU_NO);
        OP_AND: uop_o.alu = flag(ALU_NB) | flag(ALU_IC) | flag(ALU_NA) | flag(ALU_XO)
                            | flag(ALU_NO);
        OP_SRL: uop_o.alu = flag(ALU_SR);
        OP_SRA: uop_o.alu = flag(ALU_SR) | flag(ALU_SS);
        OP_JLR: uop_o.ctrl = second ? flag(CTRL_WPC) : flag(CTRL_SPC);
        OP_STB: uop_o.ctrl = flag(CTRL_MW);
        OP_LDB: uop_o.ctrl = second ? (flag(CTRL_MR) | flag(CTRL_LD)) : flag(CTRL_MR);
        OP_LDI: uop_o.ctrl = flag(CTRL_LD);
        default: uop_o.illegal = 1'b1;
      endcase
    end
    // Illegal opcodes are always a single step, whatever their low bits say.
    uop_o.last = (32'(step_i) + 32'd1 >= (hi_set ? 32'd1 : num_steps(op_lo)));
  end

endmodule

// File: rtl/decode_sequencer.sv
// Registered decoder that issues one or more handshaked micro-steps per accepted opcode.
module decode_sequencer
  import decode_pkg::*;
#(
  parameter int unsigned OPC_W     = 4,
  parameter int unsigned ALU_W     = 8,
  parameter int unsigned CTRL_W    = 8,
  parameter int unsigned MAX_STEPS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  decode_sequencer_if.slave seq_io
);

  localparam int unsigned StepW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

  state_e             state_q, state_d;
  logic [OPC_W-1:0]   op_q, op_d;
  logic [StepW-1:0]   step_q, step_d, step_inc, rom_step;
  logic [OPC_W-1:0]   rom_op;
  uop_t               uop_q, uop_d, rom_uop;
  logic               out_valid, in_ready, accept, advance, retire;

  assign out_valid = (state_q == StIssue);
  assign in_ready  = !out_valid || (seq_io.out_ready && uop_q.last);
  assign accept    = seq_io.in_valid && in_ready && !seq_io.flush;
  assign advance   = out_valid && seq_io.out_ready && !uop_q.last;
  assign retire    = out_valid && seq_io.out_ready && uop_q.last;

  assign step_inc = (step_q == StepW'(MAX_STEPS - 1)) ? step_q : step_q + 1'b1;
  // One lookup serves both a fresh opcode (step 0) and the next step of the held one.
  assign rom_op   = accept ? seq_io.opcode : op_q;
  assign rom_step = accept ? '0 : step_inc;

  uop_rom #(
    .OPC_W  (OPC_W),
    .STEP_W (StepW)
  ) u_uop_rom (
    .opcode_i (rom_op),
    .step_i   (rom_step),
    .uop_o    (rom_uop)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    step_d  = step_q;
    uop_d   = uop_q;
    if (seq_io.flush) begin
      state_d = StIdle;
      step_d  = '0;
    end else if (accept) begin
      state_d = StIssue;
      op_d    = seq_io.opcode;
      step_d  = '0;
      uop_d   = rom_uop;
    end else if (advance) begin
      step_d  = step_inc;
      uop_d   = rom_uop;
    end else if (retire) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      step_q  <= '0;
      uop_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      step_q  <= step_d;
      uop_q   <= uop_d;
    end
  end

  assign seq_io.in_ready   = in_ready;
  assign seq_io.out_valid  = out_valid;
  assign seq_io.alu_flags  = ALU_W'(uop_q.alu);
  assign seq_io.ctrl_flags = CTRL_W'(uop_q.ctrl);
  assign seq_io.step       = step_q;
  assign seq_io.last       = uop_q.last;
  assign seq_io.illegal    = uop_q.illegal;

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed scenarios plus a randomized run scored against a transaction-level model.
module tb_decode_sequencer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  decode_sequencer_if #(.OPC_W(5), .ALU_W(8), .CTRL_W(8), .MAX_STEPS(2)) sif ();

  decode_sequencer #(
    .OPC_W     (5),
    .ALU_W     (8),
    .CTRL_W    (8),
    .MAX_STEPS (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_io (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference table: returns {alu, ctrl, last, illegal} for step idx of op.
  function automatic int ref_steps(input logic [4:0] op);
    return (op == 5'h07 || op == 5'h0E) ? 2 : 1;
  endfunction

  function automatic logic [17:0] ref_uop(input logic [4:0] op, input int idx);
    logic [7:0] a;
    logic [7:0] c;
    logic       ill;
    a = 8'h00; c = 8'h00; ill = 1'b0;
    case (op)
      5'h00: a = 8'h00;
      5'h01: a = 8'hC0;
      5'h02: a = 8'h20;
      5'h03: a = 8'h2C;
      5'h04: a = 8'h7C;
      5'h05: a = 8'h02;
      5'h06: a = 8'h03;
      5'h07: c = (idx == 0) ? 8'h08 : 8'h10;
      5'h0D: c = 8'h04;
      5'h0E: c = (idx == 0) ? 8'h02 : 8'h03;
      5'h0F: c = 8'h01;
      default: ill = 1'b1;
    endcase
    return {a, c, (idx == ref_steps(op) - 1), ill};
  endfunction

  task automatic test_reset();
    total++; if (sif.out_valid !== 1'b0) begin bad++;
      $display("FAIL reset_valid: got %b want 0", sif.out_valid); end
    total++; if ({sif.alu_flags, sif.ctrl_flags} !== 16'h0000) begin bad++;
      $display("FAIL reset_flags: got %h want 0000", {sif.alu_flags, sif.ctrl_flags}); end
    total++; if ({sif.step, sif.last, sif.illegal} !== 3'b000) begin bad++;
      $display("FAIL reset_step_last_ill: got %b want 000", {sif.step, sif.last, sif.illegal}); end
    total++; if (sif.in_ready !== 1'b1) begin bad++;
      $display("FAIL reset_in_ready: got %b want 1", sif.in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] alu_exp [3];
    alu_exp[0] = 8'h00; alu_exp[1] = 8'hC0; alu_exp[2] = 8'h20;
    sif.out_ready = 1'b1; sif.in_valid = 1'b1; sif.opcode = 5'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({sif.out_valid, sif.alu_flags, sif.ctrl_flags, sif.step, sif.last, sif.illegal}
          !== {1'b1, alu_exp[i], 8'h00, 1'b0, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL b2b_step%0d: got v=%b alu=%h ctrl=%h step=%b last=%b want v=1 alu=%h ctrl=00 step=0 last=1",
                 i, sif.out_valid, sif.alu_flags, sif.ctrl_flags, sif.step, sif.last, alu_exp[i]);
      end
      if (i < 2) sif.opcode = 5'(i + 1); else sif.in_valid = 1'b0;
      #1;
      if (i < 2) begin
        total++; if (sif.in_ready !== 1'b1) begin bad++;
          $display("FAIL b2b_in_ready%0d: got %b want 1", i, sif.in_ready); end
      end
    end
    tick();
    total++; if (sif.out_valid !== 1'b0) begin bad++;
      $display("FAIL b2b_retire: got %b want 0", sif.out_valid); end
  endtask

  task automatic test_ldb();
    sif.out_ready = 1'b1; sif.in_valid = 1'b1; sif.opcode = 5'h0E;
    tick();
    sif.in_valid = 1'b0;
    #1;
    total++;
    if ({sif.out_valid, sif.ctrl_flags, sif.step, sif.last, sif.in_ready} !== {1'b1, 8'h02, 3'b000})
    begin bad++;
      $display("FAIL ldb_step0: got v=%b ctrl=%h step=%b last=%b rdy=%b want 1 02 0 0 0",
               sif.out_valid, sif.ctrl_flags, sif.step, sif.last, sif.in_ready); end
    tick();
    total++;
    if ({sif.out_valid, sif.ctrl_flags, sif.step, sif.last, sif.in_ready} !== {1'b1, 8'h03, 3'b111})
    begin bad++;
      $display("FAIL ldb_step1: got v=%b ctrl=%h step=%b last=%b rdy=%b want 1 03 1 1 1",
               sif.out_valid, sif.ctrl_flags, sif.step, sif.last, sif.in_ready); end
    tick();
    total++; if (sif.out_valid !== 1'b0) begin bad++;
      $display("FAIL ldb_retire: got %b want 0", sif.out_valid); end
  endtask

  task automatic test_jlr_stall();
    sif.out_ready = 1'b0; sif.in_valid = 1'b1; sif.opcode = 5'h07;
    tick();
    sif.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({sif.out_valid, sif.ctrl_flags, sif.step, sif.last} !== {1'b1, 8'h08, 2'b00}) begin
        bad++;
        $display("FAIL jlr_stall%0d: got v=%b ctrl=%h step=%b last=%b want 1 08 0 0",
                 i, sif.out_valid, sif.ctrl_flags, sif.step, sif.last);
      end
      tick();
    end
    sif.out_ready = 1'b1;
    tick();
    total++;
    if ({sif.out_valid, sif.ctrl_flags, sif.step, sif.last} !== {1'b1, 8'h10, 2'b11}) begin
      bad++;
      $display("FAIL jlr_step1: got v=%b ctrl=%h step=%b last=%b want 1 10 1 1",
               sif.out_valid, sif.ctrl_flags, sif.step, sif.last);
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [4:0] ops [3];
    logic       ill_exp [3];
    ops[0] = 5'h09; ops[1] = 5'h1F; ops[2] = 5'h00;
    ill_exp[0] = 1'b1; ill_exp[1] = 1'b1; ill_exp[2] = 1'b0;
    sif.out_ready = 1'b1; sif.in_valid = 1'b1; sif.opcode = ops[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({sif.out_valid, sif.alu_flags, sif.ctrl_flags, sif.last, sif.illegal}
          !== {1'b1, 16'h0000, 1'b1, ill_exp[i]}) begin
        bad++;
        $display("FAIL illegal_op%h: got v=%b flags=%h last=%b ill=%b want 1 0000 1 %b",
                 ops[i], sif.out_valid, {sif.alu_flags, sif.ctrl_flags}, sif.last, sif.illegal,
                 ill_exp[i]);
      end
      if (i < 2) sif.opcode = ops[i+1]; else sif.in_valid = 1'b0;
    end
    tick();
  endtask

  task automatic test_flush();
    sif.out_ready = 1'b0; sif.in_valid = 1'b1; sif.opcode = 5'h07;
    tick();
    sif.flush = 1'b1; sif.opcode = 5'h00;
    tick();
    sif.flush = 1'b0;
    total++;
    if ({sif.out_valid, sif.step} !== 2'b00) begin bad++;
      $display("FAIL flush_kill: got v=%b step=%b want 0 0", sif.out_valid, sif.step); end
    sif.out_ready = 1'b1;
    tick();
    sif.in_valid = 1'b0;
    total++;
    if ({sif.out_valid, sif.alu_flags, sif.ctrl_flags, sif.last, sif.illegal}
        !== {1'b1, 16'h0000, 2'b10}) begin
      bad++;
      $display("FAIL flush_then_add: got v=%b flags=%h last=%b ill=%b want 1 0000 1 0",
               sif.out_valid, {sif.alu_flags, sif.ctrl_flags}, sif.last, sif.illegal);
    end
    tick();
  endtask

  task automatic test_async_reset();
    sif.out_ready = 1'b1; sif.in_valid = 1'b1; sif.opcode = 5'h0E;
    tick();
    sif.in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({sif.out_valid, sif.alu_flags, sif.ctrl_flags, sif.step} !== 18'h0) begin bad++;
      $display("FAIL async_reset: got v=%b flags=%h step=%b want 0 0000 0",
               sif.out_valid, {sif.alu_flags, sif.ctrl_flags}, sif.step); end
    #1 rst_n = 1'b1;
    #1;
    total++; if (sif.in_ready !== 1'b1) begin bad++;
      $display("FAIL async_reset_ready: got %b want 1", sif.in_ready); end
    sif.in_valid = 1'b1; sif.opcode = 5'h0F;
    tick();
    sif.in_valid = 1'b0;
    total++;
    if ({sif.out_valid, sif.ctrl_flags, sif.last} !== {1'b1, 8'h01, 1'b1}) begin bad++;
      $display("FAIL reset_then_ldi: got v=%b ctrl=%h last=%b want 1 01 1",
               sif.out_valid, sif.ctrl_flags, sif.last); end
    tick();
  endtask

  task automatic test_random();
    logic [18:0] exp_q [$];
    logic [18:0] obs;
    logic [17:0] u;
    logic        exp_ir;
    for (int cyc = 0; cyc < 400; cyc++) begin
      sif.in_valid  = ($urandom_range(0, 3) != 0);
      sif.opcode    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31))
                                                  : 5'($urandom_range(0, 15));
      sif.flush     = ($urandom_range(0, 19) == 0);
      sif.out_ready = ($urandom_range(0, 3) != 0);
      #3;
      exp_ir = (exp_q.size() == 0) || (sif.out_ready && exp_q.size() == 1);
      total++;
      if (sif.out_valid !== (exp_q.size() != 0)) begin bad++;
        $display("FAIL rand_valid cyc%0d: got %b want %b", cyc, sif.out_valid, exp_q.size() != 0);
      end
      total++;
      if (sif.in_ready !== exp_ir) begin bad++;
        $display("FAIL rand_in_ready cyc%0d: got %b want %b", cyc, sif.in_ready, exp_ir);
      end
      if (exp_q.size() != 0) begin
        obs = {sif.alu_flags, sif.ctrl_flags, sif.step, sif.last, sif.illegal};
        total++;
        if (obs !== exp_q[0]) begin bad++;
          $display("FAIL rand_uop cyc%0d: got %h want %h", cyc, obs, exp_q[0]);
        end
      end
      if (sif.flush) begin
        exp_q.delete();
      end else begin
        if (sif.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (sif.in_valid && exp_ir) begin
          for (int i = 0; i < ref_steps(sif.opcode); i++) begin
            u = ref_uop(sif.opcode, i);
            exp_q.push_back({u[17:2], 1'(i), u[1:0]});
          end
        end
      end
      tick();
    end
    sif.in_valid = 1'b0; sif.flush = 1'b0; sif.out_ready = 1'b1;
    repeat (3) tick();
    total++;
    if (sif.out_valid !== 1'b0) begin bad++;
      $display("FAIL rand_drain: got %b want 0", sif.out_valid); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    sif.in_valid = 1'b0; sif.opcode = '0; sif.flush = 1'b0; sif.out_ready = 1'b0;
    #12 rst_n = 1'b1;
    tick();
    test_reset();
    test_back_to_back();
    test_ldb();
    test_jlr_stall();
    test_illegal();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
